// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, CONTROL bit positions and FSM state encoding.
// Used by both uart_tx and uart_rx.
package uart_pkg;

    localparam logic [2:0] ADDR_PERIOD  = 3'b100;
    localparam logic [2:0] ADDR_TXDATA  = 3'b110;
    localparam logic [2:0] ADDR_CONTROL = 3'b111;

    localparam int unsigned CTRL_TXEN     = 0;
    localparam int unsigned CTRL_TXRDY    = 1;
    localparam int unsigned CTRL_IDLE     = 2;
    localparam int unsigned CTRL_OVERFLOW = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StData  = 3'd3,
        StStop  = 3'd4
    } uart_state_e;

    function automatic logic [7:0] control_word(input logic txen, input logic txrdy,
                                                input logic idle, input logic overflow);
        logic [7:0] w;
        w                = 8'h00;
        w[CTRL_TXEN]     = txen;
        w[CTRL_TXRDY]    = txrdy;
        w[CTRL_IDLE]     = idle;
        w[CTRL_OVERFLOW] = overflow;
        return w;
    endfunction

endpackage

// File: rtl/fifo_tx.sv
// Synchronous 8-bit TX FIFO with first-word-fall-through output and synchronous flush.
module fifo_tx #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       srst,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_rd;
    logic          do_wr;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // A pop in the same clock frees a slot, so a write to a full FIFO still lands.
    assign do_rd = rd_en && !empty && !srst;
    assign do_wr = wr_en && (!full || do_rd) && !srst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (srst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: register interface, baud divider (16 ticks per bit) and frame FSM
// feeding a TX FIFO.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [7:0]  PERIOD = 8'h1A,
    parameter int unsigned DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic       wren,
    input  logic       rden,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       txout
);

    logic [7:0]  period_q, period_d;
    logic        txen_q, txen_d;
    logic        overflow_q, overflow_d;
    uart_state_e state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [7:0]  div_period_q, div_period_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txout_q, txout_d;

    logic       wr_period, wr_txdata, wr_control;
    logic       push, pop, full, empty;
    logic [7:0] fifo_dout;
    logic       in_frame, tick, bit_done, start_ok;

    assign wr_period  = wren && (addr == ADDR_PERIOD);
    assign wr_txdata  = wren && (addr == ADDR_TXDATA);
    assign wr_control = wren && (addr == ADDR_CONTROL);

    assign pop  = (state_q == StLoad);
    assign push = wr_txdata && txen_q && (!full || pop);

    fifo_tx #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .srst (!txen_q),
        .wr_en(push),
        .din  (din),
        .rd_en(pop),
        .dout (fifo_dout),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        period_d   = wr_period ? din : period_q;
        txen_d     = wr_control ? din[CTRL_TXEN] : txen_q;
        overflow_d = overflow_q;
        if (wr_control && din[CTRL_OVERFLOW]) begin
            overflow_d = 1'b0;
        end else if (wr_txdata && txen_q && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    assign in_frame = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign tick     = in_frame && (div_cnt_q == div_period_q);
    assign bit_done = tick && (tick_cnt_q == 4'hF);
    // Use the post-write TXEN so a same-cycle disable suppresses the LOAD (and its pop).
    assign start_ok = txen_d && !empty;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        div_period_d = div_period_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;

        if (in_frame) begin
            if (tick) begin
                div_cnt_d    = 8'd0;
                div_period_d = period_q;
                tick_cnt_d   = tick_cnt_q + 4'd1;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                div_cnt_d  = 8'd0;
                tick_cnt_d = 4'd0;
                if (start_ok) state_d = StLoad;
            end
            StLoad: begin
                shift_d      = fifo_dout;
                bit_idx_d    = 3'd0;
                div_cnt_d    = 8'd0;
                div_period_d = period_q;
                tick_cnt_d   = 4'd0;
                state_d      = StStart;
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) state_d = start_ok ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered from next state so txout lines up with the state it represents.
        unique case (state_d)
            StStart: txout_d = 1'b0;
            StData:  txout_d = shift_d[0];
            default: txout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q     <= PERIOD;
            txen_q       <= 1'b0;
            overflow_q   <= 1'b0;
            state_q      <= StIdle;
            div_cnt_q    <= 8'd0;
            div_period_q <= PERIOD;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            txout_q      <= 1'b1;
        end else begin
            period_q     <= period_d;
            txen_q       <= txen_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            div_period_q <= div_period_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            txout_q      <= txout_d;
        end
    end

    assign txout = txout_q;

    always_comb begin
        dout = 8'h00;
        if (rden) begin
            unique case (addr)
                ADDR_PERIOD:  dout = period_q;
                ADDR_CONTROL: dout = control_word(txen_q, !full,
                                                  (state_q == StIdle) && empty, overflow_q);
                default:      dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected reads and frames are queued by the stimulus and
// checked by independent read and serial-line monitors.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] addr;
    logic       wren;
    logic       rden;
    logic [7:0] din;
    logic [7:0] dout;
    logic       txout;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         b2b;
    } frame_t;

    frame_t     frame_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] rd_exp;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int frames_done = 0;
    int exp_frames = 0;
    int cur_period = 32'h1A;

    uart_tx #(
        .PERIOD(8'h1A),
        .DEPTH (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wren (wren),
        .rden (rden),
        .din  (din),
        .dout (dout),
        .txout(txout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        wren = 1'b1;
        if (a == ADDR_PERIOD) cur_period = int'(d);
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, input logic [7:0] e);
        @(negedge clk);
        addr = a;
        rden = 1'b1;
        rd_q.push_back(e);
        @(negedge clk);
        rden = 1'b0;
    endtask

    // mode 0: sent from idle, start expected 2 clks later; 1: back-to-back; 2: timing free
    task automatic send(input logic [7:0] d, input int mode);
        frame_t f;
        reg_write(ADDR_TXDATA, d);
        f.data  = d;
        f.b2b   = (mode == 1);
        f.start = (mode == 0) ? cyc + 2 : -1;
        frame_q.push_back(f);
        exp_frames++;
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while (frames_done < exp_frames && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_done, exp_frames);
        repeat (2) @(negedge clk);
    endtask

    // Read monitor
    always @(negedge clk) begin
        #1;
        if (rden) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected: got %0h required no read", dout);
            end else begin
                rd_exp = rd_q.pop_front();
                check($sformatf("read_addr%0d", addr), dout, rd_exp);
            end
        end
    end

    // Serial monitor: decodes each frame cycle by cycle and scores it
    initial begin : serial_mon
        int s, bitclks, prev_start, prev_bitclks;
        logic [9:0] bits;
        bit aborted, glitch;
        frame_t e;
        prev_start   = -1;
        prev_bitclks = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txout === 1'b0) begin
                s       = cyc;
                bitclks = 16 * (cur_period + 1);
                aborted = 1'b0;
                glitch  = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < bitclks && !aborted; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clk);
                            if (reset !== 1'b0) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (c == 0) bits[b] = txout;
                            else if (txout !== bits[b]) glitch = 1'b1;
                        end
                    end
                end
                if (!aborted) begin
                    if (frame_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got data %02h required no frame",
                                 bits[8:1]);
                    end else begin
                        e = frame_q.pop_front();
                        check("frame_data", bits[8:1], e.data);
                        check("stop_bit", bits[9], 1);
                        check("bit_stable", glitch, 0);
                        if (e.b2b) check("b2b_start", s, prev_start + 10 * prev_bitclks + 1);
                        else if (e.start >= 0) check("start_latency", s, e.start);
                    end
                    frames_done++;
                    prev_start   = s;
                    prev_bitclks = bitclks;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        addr  = 3'b000;
        wren  = 1'b0;
        rden  = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        check("txout_in_reset", txout, 1);
        reset = 1'b0;

        // Reset values and read decode
        reg_read(ADDR_PERIOD, 8'h1A);
        reg_read(ADDR_CONTROL, 8'h06);
        reg_read(3'b000, 8'h00);
        addr = ADDR_CONTROL;
        #1 check("dout_no_rden", dout, 0);

        // Single 0x55 frame at period 0
        reg_write(ADDR_PERIOD, 8'h00);
        reg_read(ADDR_PERIOD, 8'h00);
        reg_write(ADDR_CONTROL, 8'h01);
        reg_read(ADDR_CONTROL, 8'h07);
        send(8'h55, 0);
        reg_read(ADDR_TXDATA, 8'h00);
        wait_frames(400);
        reg_read(ADDR_CONTROL, 8'h07);

        // Slower divider: period 2 gives 48 clks per bit
        reg_write(ADDR_PERIOD, 8'h02);
        reg_read(ADDR_PERIOD, 8'h02);
        send(8'h96, 0);
        wait_frames(1000);
        reg_write(ADDR_PERIOD, 8'h00);

        // Back-to-back frames
        send(8'hA3, 0);
        send(8'h3C, 1);
        wait_frames(800);

        // Overflow: one frame in flight, then 17 pushes into the 16-entry FIFO
        send(8'h10, 0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1);
        reg_write(ADDR_TXDATA, 8'h30);
        reg_read(ADDR_CONTROL, 8'h09);
        reg_write(ADDR_CONTROL, 8'h09);
        reg_read(ADDR_CONTROL, 8'h01);
        wait_frames(17 * 161 + 500);

        // Disable mid-DATA with three bytes queued: only the current frame goes out
        send(8'h5A, 0);
        reg_write(ADDR_TXDATA, 8'h11);
        reg_write(ADDR_TXDATA, 8'h22);
        reg_write(ADDR_TXDATA, 8'h33);
        repeat (30) @(negedge clk);
        reg_write(ADDR_CONTROL, 8'h00);
        reg_read(ADDR_CONTROL, 8'h02);
        wait_frames(300);
        reg_read(ADDR_CONTROL, 8'h06);
        check("txout_idle_after_flush", txout, 1);

        // TXDATA write with TXEN=0 is dropped silently
        reg_write(ADDR_TXDATA, 8'h77);
        reg_read(ADDR_CONTROL, 8'h06);
        reg_write(ADDR_CONTROL, 8'h01);
        repeat (300) @(negedge clk);
        check("no_stray_frame", frames_done, exp_frames);
        reg_read(ADDR_CONTROL, 8'h07);

        // Reset in the middle of a data bit of 0x00
        reg_write(ADDR_TXDATA, 8'h00);
        repeat (24) @(negedge clk);
        check("txout_data_bit", txout, 0);
        #2 reset = 1'b1;
        #1 check("txout_on_reset", txout, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        cur_period = 32'h1A;
        reg_read(ADDR_CONTROL, 8'h06);
        reg_read(ADDR_PERIOD, 8'h1A);
        repeat (300) @(negedge clk);
        check("no_frame_after_reset", frames_done, exp_frames);
        check("txout_after_reset", txout, 1);

        check("rd_q_drained", rd_q.size(), 0);
        check("frame_q_drained", frame_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter PERIOD, default 8'h1A, reset value of the baud period register.
REQ-002 Parameter DEPTH, default 16, number of TX FIFO entries (power of two).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 addr  in  3  register address: 3'b100 PERIOD, 3'b110 TXDATA, 3'b111 CONTROL.
REQ-006 wren  in  1  write strobe, one clk per access.
REQ-007 rden  in  1  read strobe.
REQ-008 din  in  8  write data.
REQ-009 dout  out  8  read data, combinational from addr/rden; 8'h00 when rden=0 or unmapped addr.
REQ-010 txout  out  1  serial data out, registered, idles high.

Function
REQ-011 PERIOD write shall load the period register; read returns it; takes effect at next divider reload.
REQ-012 Baud divider shall count 0..period, emitting a one-clk tick at count=period, so tick spacing is period+1 clks; period=0 gives a tick every clk.
REQ-013 Divider shall be held at 0 outside a frame and restarted at 0 on the LOAD cycle, so every bit lasts exactly 16 ticks = 16*(period+1) clks.
REQ-014 TXDATA write with TXEN=1 and FIFO not full shall push din; TXDATA read returns 8'h00.
REQ-015 TXDATA write while full shall be discarded and set OVERFLOW; if a pop occurs in the same clk, the push is accepted and OVERFLOW is not set.
REQ-016 TXDATA write with TXEN=0 shall be discarded without setting OVERFLOW.
REQ-017 CONTROL read: bit0 TXEN, bit1 TXRDY (=~full), bit2 IDLE (state IDLE and FIFO empty), bit3 OVERFLOW, bits7:4 zero.
REQ-018 CONTROL write: din[0] loads TXEN; din[3]=1 clears OVERFLOW (write-1-clear); other bits ignored.
REQ-019 TXEN=0 shall flush the FIFO synchronously; any frame in progress completes unchanged.
REQ-020 FSM states: IDLE, LOAD, START, DATA, STOP.
REQ-021 IDLE: txout=1; if TXEN=1 and FIFO non-empty -> LOAD.
REQ-022 LOAD: pop FIFO head into 8-bit shift register, clear bit index, restart divider -> START (one clk).
REQ-023 START: txout=0 for 16 ticks -> DATA.
REQ-024 DATA: txout=shift[0] (LSB first); every 16 ticks shift right and increment index; after 8th bit -> STOP.
REQ-025 STOP: txout=1 for 16 ticks; then LOAD if TXEN=1 and FIFO non-empty, else IDLE.
REQ-026 First start-bit clk on txout shall occur 2 clks after the IDLE cycle that sees a non-empty FIFO; back-to-back frames shall have one extra LOAD clk of mark between stop and next start.
REQ-027 Frame total = 160*(period+1) clks plus the LOAD clk.
REQ-028 Simultaneous CONTROL TXEN=0 write and LOAD decision: TXEN write wins; no pop occurs.

Reset
REQ-029 On reset: period=PERIOD, TXEN=0, OVERFLOW=0, FIFO empty, state IDLE, divider 0, bit index 0, shift register 0, txout=1.
REQ-030 Reset mid-frame shall abort immediately, driving txout=1 on reset assertion.

Structure
REQ-031 Address codes, CONTROL bit positions and FSM state encodings shall live in the shared uart package used by uart_rx.
REQ-032 TX FIFO shall be a sub-module fifo_tx: synchronous 8-bit x DEPTH, srst, wr_en, rd_en, full, empty, first-word-fall-through dout.

Verification
REQ-033 Reset -> txout=1, PERIOD read 8'h1A, CONTROL read 8'h06.
REQ-034 Write PERIOD 8'h00, CONTROL 8'h01, TXDATA 8'h55 -> txout 0 for 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then 1 for 16 clks; IDLE=1 after 161 clks.
REQ-035 TXEN=1, period 0, push 17 bytes with no intervening ticks -> bytes 1-16 accepted, 17th dropped, CONTROL bit3=1; write CONTROL 8'h09 -> bit3=0, TXEN stays 1.
REQ-036 Push 8'hA3 then 8'h3C back-to-back -> both frames transmitted in order, exactly one LOAD clk of mark between stop and second start.
REQ-037 Mid-DATA of frame 1 with 3 bytes queued, write CONTROL 8'h00 -> frame 1 completes, FIFO empty, txout stays 1, TXRDY=1.
REQ-038 Assert reset during DATA -> txout=1 same cycle; after release, CONTROL reads 8'h06 and no frame starts.
